uart_tx_frame: RTL and testbench



---
 rtl/uart_tx_frame.sv | 149 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, stop bits.
// Bit timing advances on i_en-qualified cycles of the OSR x baud clock.
module uart_tx_frame #(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int IW = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 done_q, done_d;
    logic                 bit_end;

    // Next-state logic: accept, bit timer, and per-state line level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        bit_end = i_en && (cnt_q == CW'(OSR - 1));

        if (state_q != IDLE && i_en) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (i_valid && ready_q) begin
                    state_d = START;
                    shift_d = i_data;
                    par_d   = (^i_data) ^ (PARITY == 2);
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IW'(DATA_BITS - 1)) begin
                        idx_d = '0;
                        if (PARITY != 0) begin
                            state_d = PAR;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        idx_d   = idx_q + IW'(1);
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    idx_d   = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx_q == IW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset aborts any frame, line goes high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = ~ready_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four configurations side by side,
// expected waveforms built from the frame format, checked bit by bit.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] data;
    logic [3:0] valid;
    logic [3:0] tx, ready, busy, done;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    uart_tx_frame u0 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_valid(valid[0]), .o_ready(ready[0]), .o_tx(tx[0]),
        .o_busy(busy[0]), .o_done(done[0])
    );

    uart_tx_frame #(.PARITY(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_valid(valid[1]), .o_ready(ready[1]), .o_tx(tx[1]),
        .o_busy(busy[1]), .o_done(done[1])
    );

    uart_tx_frame #(.PARITY(2)) u2 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data),
        .i_valid(valid[2]), .o_ready(ready[2]), .o_tx(tx[2]),
        .o_busy(busy[2]), .o_done(done[2])
    );

    uart_tx_frame #(.OSR(4), .DATA_BITS(5), .STOP_BITS(2)) u3 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_data(data[4:0]),
        .i_valid(valid[3]), .o_ready(ready[3]), .o_tx(tx[3]),
        .o_busy(busy[3]), .o_done(done[3])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        assert (got === exp) else begin
            err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Send one byte to instance s and check the whole frame cycle by cycle.
    task automatic run_frame(input string tag, input int s, input logic [7:0] d,
                             input int nd, input int par, input int ns,
                             input int osr, input bit tog, input bit hold);
        logic [15:0] exp;
        logic        p;
        int          nb, bc, good, k;
        exp = '0;
        p   = 1'b0;
        exp[0] = 1'b0;
        for (int i = 0; i < nd; i++) begin
            exp[1+i] = d[i];
            p        = p ^ d[i];
        end
        nb = 1 + nd;
        if (par != 0) begin
            exp[nb] = (par == 2) ? ~p : p;
            nb++;
        end
        for (int i = 0; i < ns; i++) begin
            exp[nb] = 1'b1;
            nb++;
        end
        bc = tog ? 2 * osr : osr;
        k  = 0;

        data     = d;
        valid[s] = 1'b1;
        en       = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) valid[s] = 1'b0;
        data = ~d;
        chk({tag, " accept"}, {30'd0, ready[s], busy[s]}, 32'd1);

        for (int b = 0; b < nb; b++) begin
            good = 0;
            for (int c = 0; c < bc; c++) begin
                if (tx[s] === exp[b] && ready[s] === 1'b0 && done[s] === 1'b0)
                    good++;
                en = tog ? (((k + 1) % 2) == 0) : 1'b1;
                k++;
                @(posedge clk);
                #1;
            end
            chk($sformatf("%s bit%0d", tag, b), good, bc);
        end
        en = 1'b1;
        chk({tag, " end"}, {28'd0, ready[s], done[s], tx[s], busy[s]}, 32'hE);
        if (!hold) begin
            @(posedge clk);
            #1;
            chk({tag, " idle"}, {29'd0, ready[s], done[s], tx[s]}, 32'h5);
        end
    endtask

    initial begin
        int good;
        rst   = 1'b1;
        en    = 1'b1;
        data  = 8'h00;
        valid = 4'h0;
        #1;
        chk("rst tx", {28'd0, tx}, 32'hF);
        chk("rst ready", {28'd0, ready}, 32'hF);
        chk("rst busy_done", {24'd0, busy, done}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_frame("8n1_a5", 0, 8'hA5, 8, 0, 1, 16, 1'b0, 1'b0);
        run_frame("gate_3c", 0, 8'h3C, 8, 0, 1, 16, 1'b1, 1'b0);
        run_frame("even_07", 1, 8'h07, 8, 1, 1, 16, 1'b0, 1'b0);
        run_frame("odd_07", 2, 8'h07, 8, 2, 1, 16, 1'b0, 1'b0);

        run_frame("b2b_55", 0, 8'h55, 8, 0, 1, 16, 1'b0, 1'b1);
        run_frame("b2b_aa", 0, 8'hAA, 8, 0, 1, 16, 1'b0, 1'b0);

        run_frame("cfg_1f", 3, 8'h1F, 5, 0, 2, 4, 1'b0, 1'b0);

        // Abort a frame mid-START with i_valid still high.
        valid[0] = 1'b1;
        data     = 8'hF0;
        @(posedge clk);
        #1;
        chk("abort started", {31'd0, tx[0]}, 32'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort async", {28'd0, tx[0], ready[0], busy[0], done[0]}, 32'hC);
        @(negedge clk);
        valid[0] = 1'b0;
        rst      = 1'b0;
        good     = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (tx[0] === 1'b1 && ready[0] === 1'b1 && done[0] === 1'b0)
                good++;
        end
        chk("abort quiet", good, 20);
        run_frame("fresh_81", 0, 8'h81, 8, 0, 1, 16, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
